// File: rtl/fifo_rr_drain_if.sv
// Bundle between the round-robin drain, the FIFO read ports it serves and the
// downstream valid/ready consumer. The drain itself connects through "master".
interface fifo_rr_drain_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  localparam int SW = $clog2(NREQ);

  logic [NREQ-1:0]       rempty;
  logic [NREQ*DSIZE-1:0] rdata;
  logic [NREQ-1:0]       req_en;
  logic [NREQ-1:0]       rinc;
  logic                  out_valid;
  logic [DSIZE-1:0]      out_data;
  logic [SW-1:0]         out_src;
  logic                  out_ready;
  logic [NREQ-1:0]       grant;

  modport master (
    input  rempty, rdata, req_en, out_ready,
    output rinc, out_valid, out_data, out_src, grant
  );

  modport slave (
    output rempty, rdata, req_en, out_ready,
    input  rinc, out_valid, out_data, out_src, grant
  );
endinterface

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NREQ FWFT FIFO read ports into one registered valid/ready
// stream; each grant lasts up to BURST pops, then the pointer moves past it.
module fifo_rr_drain #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic           clk,
  input  logic           resetb,
  fifo_rr_drain_if.master bus
);
  localparam int SW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [SW-1:0]     gidx, gidx_nxt;
  logic [NREQ-1:0]   grant_q, grant_nxt;
  logic [CW-1:0]     burst_cnt, burst_cnt_nxt;
  logic [NREQ-1:0]   elig;
  logic [SW-1:0]     pick;
  logic [SW:0]       cand;
  logic              found;
  logic              space;
  logic              pop;
  logic              last_pop;
  logic              valid_q;
  logic [DSIZE-1:0]  data_q;
  logic [SW-1:0]     src_q;
  logic [DSIZE-1:0]  head;

  assign elig  = ~bus.rempty & bus.req_en;
  assign space = !valid_q || bus.out_ready;
  assign head  = bus.rdata[gidx*DSIZE +: DSIZE];
  // A disabled requester is never popped, even on the cycle it causes the exit.
  assign pop   = (state == XFER) && space && !bus.rempty[gidx] && bus.req_en[gidx];

  assign bus.rinc      = pop ? grant_q : '0;
  assign bus.grant     = grant_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

  // Search starts at rr_ptr and wraps modulo NREQ, which need not be a power of 2.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (SW+1)'(k);
      if (cand >= (SW+1)'(NREQ)) cand = cand - (SW+1)'(NREQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand[SW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    gidx_nxt      = gidx;
    grant_nxt     = grant_q;
    burst_cnt_nxt = burst_cnt;
    last_pop      = pop && ((burst_cnt + 1'b1) == CW'(BURST));
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt     = XFER;
          gidx_nxt      = pick;
          grant_nxt     = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          burst_cnt_nxt = '0;
        end
      end
      XFER: begin
        if (pop) burst_cnt_nxt = burst_cnt + 1'b1;
        if (last_pop || (space && bus.rempty[gidx]) || !bus.req_en[gidx]) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = (gidx == SW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gidx      <= '0;
      grant_q   <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      gidx      <= gidx_nxt;
      grant_q   <= grant_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Output register holds its word under backpressure; a reset drops it.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else if (pop) begin
      valid_q <= 1'b1;
      data_q  <= head;
      src_q   <= gidx;
    end else if (space) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fifo_rr_drain.sv
// Self-checking bench: 4-input drain (BURST=4) and 3-input drain (BURST=2)
// fed from behavioural FWFT FIFO models owned by the bench.
module tb_fifo_rr_drain;
  logic clk = 1'b0;
  logic resetb;

  fifo_rr_drain_if #(.NREQ(4), .DSIZE(8)) bus ();
  fifo_rr_drain_if #(.NREQ(3), .DSIZE(8)) bus3 ();

  fifo_rr_drain #(.NREQ(4), .DSIZE(8), .BURST(4)) u_dut (
    .clk(clk), .resetb(resetb), .bus(bus)
  );
  fifo_rr_drain #(.NREQ(3), .DSIZE(8), .BURST(2)) u_dut3 (
    .clk(clk), .resetb(resetb), .bus(bus3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [3:0] grant;
    logic [3:0] rinc;
    logic       valid;
    logic [1:0] src;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [22];

  int checks = 0;
  int errors = 0;
  // FIFOs 0..3 feed u_dut, 4..6 feed u_dut3; word = {fifo, push index}
  logic [7:0] mem [7][64];
  int wp [7];
  int rp [7];
  int ep [7];
  int exp_src_q [$];
  logic [7:0] exp_data_q [$];
  int first_cyc, last_cyc;
  logic watch2 = 1'b0;
  int bad2 = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int f, input int n);
    for (int i = 0; i < n; i++) begin
      mem[f][wp[f]] = {4'(f), 4'(wp[f])};
      wp[f]++;
    end
  endtask

  task automatic expect_words(input int f, input int n);
    for (int i = 0; i < n; i++) begin
      exp_data_q.push_back(mem[f][ep[f]]);
      exp_src_q.push_back(f < 4 ? f : f - 4);
      ep[f]++;
    end
  endtask

  function automatic void refresh();
    logic [3:0]  e4;
    logic [31:0] d4;
    logic [2:0]  e3;
    logic [23:0] d3;
    for (int f = 0; f < 4; f++) begin
      e4[f] = (wp[f] == rp[f]);
      d4[f*8 +: 8] = e4[f] ? 8'h00 : mem[f][rp[f]];
    end
    for (int f = 0; f < 3; f++) begin
      e3[f] = (wp[f+4] == rp[f+4]);
      d3[f*8 +: 8] = e3[f] ? 8'h00 : mem[f+4][rp[f+4]];
    end
    bus.rempty  = e4;
    bus.rdata   = d4;
    bus3.rempty = e3;
    bus3.rdata  = d3;
  endfunction

  task automatic pop_one(input int f, input logic hit);
    if (hit) begin
      checks++;
      if (wp[f] == rp[f]) begin
        errors++;
        $display("[TB] FAIL rinc_on_empty: fifo %0d popped while empty, required no pop", f);
      end else begin
        rp[f]++;
      end
    end
  endtask

  // FIFO model: pops on the edge where rinc was seen, then republishes heads.
  initial begin
    logic [3:0] m4;
    logic [2:0] m3;
    logic       live;
    #2;
    refresh();
    forever begin
      @(negedge clk);
      m4 = bus.rinc;
      m3 = bus3.rinc;
      @(posedge clk);
      live = resetb;
      #2;
      if (live) begin
        if (m4 != 4'h0) check_output("rinc_onehot", $countones(m4), 1);
        for (int f = 0; f < 4; f++) pop_one(f, m4[f]);
        for (int f = 0; f < 3; f++) pop_one(f + 4, m3[f]);
      end
      refresh();
    end
  end

  task automatic apply_stimulus(input int i);
    resetb        = vecs[i].rst;
    bus.out_ready = vecs[i].rdy;
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      apply_stimulus(i);
      @(negedge clk);
      check_output($sformatf("v%0d grant", i), 32'(bus.grant), 32'(vecs[i].grant));
      check_output($sformatf("v%0d rinc", i), 32'(bus.rinc), 32'(vecs[i].rinc));
      check_output($sformatf("v%0d valid", i), 32'(bus.out_valid), 32'(vecs[i].valid));
      check_output($sformatf("v%0d src", i), 32'(bus.out_src), 32'(vecs[i].src));
      check_output($sformatf("v%0d data", i), 32'(bus.out_data), 32'(vecs[i].data));
      step();
    end
  endtask

  task automatic drain_check(input int which, input int n, input int max_cyc);
    int got = 0;
    int cyc = 0;
    logic v;
    logic [7:0] d;
    int s;
    first_cyc = -1;
    last_cyc  = -1;
    while (got < n && cyc < max_cyc) begin
      @(negedge clk);
      if (which == 0) begin
        v = bus.out_valid & bus.out_ready;
        d = bus.out_data;
        s = int'(bus.out_src);
        if (watch2 && (bus.rinc[2] || bus.grant[2])) bad2++;
      end else begin
        v = bus3.out_valid & bus3.out_ready;
        d = bus3.out_data;
        s = int'(bus3.out_src);
      end
      if (v) begin
        if (exp_src_q.size() == 0) begin
          check_output("unexpected_word", 32'(d), 32'hFFFF_FFFF);
        end else begin
          check_output($sformatf("dut%0d word%0d src", which, got), 32'(s), 32'(exp_src_q.pop_front()));
          check_output($sformatf("dut%0d word%0d data", which, got), 32'(d), 32'(exp_data_q.pop_front()));
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      cyc++;
    end
    check_output($sformatf("dut%0d words_before_timeout", which), 32'(got), 32'(n));
    step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 4'h1, 4'h1, 1'b0, 2'd0, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 4'h1, 4'h1, 1'b1, 2'd0, 8'h00};
    vecs[4]  = '{1'b1, 1'b1, 4'h1, 4'h1, 1'b1, 2'd0, 8'h01};
    vecs[5]  = '{1'b1, 1'b1, 4'h1, 4'h0, 1'b1, 2'd0, 8'h02};
    vecs[6]  = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 8'h02};
    vecs[7]  = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 8'h02};
    vecs[8]  = '{1'b1, 1'b1, 4'h2, 4'h2, 1'b0, 2'd0, 8'h02};
    vecs[9]  = '{1'b1, 1'b1, 4'h2, 4'h2, 1'b1, 2'd1, 8'h10};
    for (int i = 10; i <= 14; i++) vecs[i] = '{1'b1, 1'b0, 4'h2, 4'h0, 1'b1, 2'd1, 8'h11};
    vecs[15] = '{1'b1, 1'b1, 4'h2, 4'h2, 1'b1, 2'd1, 8'h11};
    vecs[16] = '{1'b1, 1'b1, 4'h2, 4'h2, 1'b1, 2'd1, 8'h12};
    vecs[17] = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 2'd1, 8'h13};
    vecs[18] = '{1'b1, 1'b1, 4'h2, 4'h2, 1'b0, 2'd1, 8'h13};
    vecs[19] = '{1'b1, 1'b1, 4'h2, 4'h2, 1'b1, 2'd1, 8'h14};
    vecs[20] = '{1'b1, 1'b1, 4'h2, 4'h0, 1'b1, 2'd1, 8'h15};
    vecs[21] = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 2'd1, 8'h15};

    resetb         = 1'b0;
    bus.req_en     = 4'hF;
    bus.out_ready  = 1'b1;
    bus3.req_en    = 3'h7;
    bus3.out_ready = 1'b1;

    $display("[TB] reset and first burst from FIFO0");
    push(0, 3);
    run_vectors(0, 6);

    $display("[TB] backpressure mid-burst on FIFO1");
    push(1, 6);
    run_vectors(7, 21);

    $display("[TB] four-way rotation after reset");
    resetb = 1'b0;
    step();
    resetb = 1'b1;
    for (int f = 0; f < 7; f++) ep[f] = wp[f];
    for (int f = 0; f < 4; f++) push(f, 8);
    for (int r = 0; r < 2; r++)
      for (int f = 0; f < 4; f++) expect_words(f, 4);
    drain_check(0, 32, 200);
    check_output("rotation_span", 32'(last_cyc - first_cyc), 32'd38);

    $display("[TB] dry-out and masked FIFO2");
    bus.req_en = 4'b1011;
    push(1, 2);
    push(2, 6);
    push(3, 3);
    expect_words(1, 2);
    expect_words(3, 3);
    watch2 = 1'b1;
    drain_check(0, 5, 60);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rinc[2] || bus.grant[2] || bus.out_valid) bad2++;
    end
    watch2 = 1'b0;
    check_output("fifo2_never_served", 32'(bad2), 32'd0);
    check_output("fifo2_words_left", 32'(wp[2] - rp[2]), 32'd6);
    step();
    bus.req_en = 4'hF;
    expect_words(2, 6);
    drain_check(0, 6, 60);

    $display("[TB] non-power-of-2 wrap on 3-input drain");
    push(5, 2);
    expect_words(5, 2);
    drain_check(1, 2, 40);
    push(4, 4);
    expect_words(4, 4);
    drain_check(1, 4, 40);
    push(4, 1);
    push(5, 1);
    push(6, 1);
    expect_words(5, 1);
    expect_words(6, 1);
    expect_words(4, 1);
    drain_check(1, 3, 40);

    $display("[TB] asynchronous reset mid-burst");
    push(0, 4);
    step();
    step();
    step();
    check_output("pre_reset valid", 32'(bus.out_valid), 32'd1);
    check_output("pre_reset data", 32'(bus.out_data), 32'(mem[0][ep[0] + 1]));
    resetb = 1'b0;
    push(1, 1);
    push(3, 1);
    @(negedge clk);
    check_output("in_reset valid", 32'(bus.out_valid), 32'd0);
    check_output("in_reset grant", 32'(bus.grant), 32'd0);
    check_output("in_reset rinc", 32'(bus.rinc), 32'd0);
    check_output("in_reset data", 32'(bus.out_data), 32'd0);
    check_output("fifo0_words_left", 32'(wp[0] - rp[0]), 32'd2);
    step();
    resetb = 1'b1;
    ep[0] += 2;
    expect_words(0, 2);
    expect_words(1, 1);
    expect_words(3, 1);
    drain_check(0, 4, 60);

    for (int f = 0; f < 7; f++)
      check_output($sformatf("fifo%0d_empty_at_end", f), 32'(wp[f] - rp[f]), 32'd0);
    check_output("no_leftover_expectations", 32'(exp_src_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
